// File: rtl/router_pkg.sv
// Shared router constants: flit field map, port indices and default flit width.
package router_pkg;

  localparam int unsigned FLIT_W_DEF   = 32;

  // Flit field positions
  localparam int unsigned GOLDEN_BIT   = 0;
  localparam int unsigned EJECT_BIT    = 1;
  localparam int unsigned IN_PORT_LSB  = 2;
  localparam int unsigned OUT_PORT_LSB = 4;
  localparam int unsigned SRC_LSB      = 7;
  localparam int unsigned DST_LSB      = 11;
  localparam int unsigned SEQ_LSB      = 15;

  // Link channel indices
  localparam int unsigned PORT_N       = 0;
  localparam int unsigned PORT_E       = 1;
  localparam int unsigned PORT_S       = 2;
  localparam int unsigned PORT_W       = 3;
  localparam int unsigned PORT_LOCAL   = 4;

endpackage

// File: rtl/inject_queue_engine_inj_fifo.sv
// Local-core injection FIFO: synchronous, power-of-2 depth, no bypass.
module inj_fifo #(
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [FLIT_W-1:0]           push_data,
  input  logic                        pop,
  output logic [FLIT_W-1:0]           head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(QDEPTH):0]     count
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;

  logic [FLIT_W-1:0] mem [QDEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-2 depth; count tracks fill level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inject_queue_engine.sv
// Injection stage: places the queued local head flit into a slot vacated by ejection.
module inject_queue_engine
  import router_pkg::*;
#(
  parameter int unsigned FLIT_W       = FLIT_W_DEF,
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS*FLIT_W-1:0]   in_flits,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS*FLIT_W-1:0]   out_flits,
  output logic [NUM_PORTS-1:0]          out_valid,
  input  logic [FLIT_W-1:0]             inj_data,
  input  logic                          inj_valid,
  output logic                          inj_ready,
  output logic                          inj_grant,
  output logic [$clog2(NUM_PORTS)-1:0]  inj_port,
  output logic [$clog2(QDEPTH):0]       occupancy,
  output logic                          starve
);

  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [FLIT_W-1:0]           head;
  logic [FLIT_W-1:0]           head_clr;
  logic                        full;
  logic                        empty;
  logic [NUM_PORTS-1:0]        free_c;
  logic                        any_free;
  logic                        inject;
  logic                        found;
  int unsigned                 scan_idx;
  logic [PW-1:0]               sel;
  logic [PW-1:0]               rr_ptr;
  logic [SW-1:0]               starve_cnt;
  logic [NUM_PORTS*FLIT_W-1:0] nxt_flits;
  logic [NUM_PORTS-1:0]        nxt_valid;

  inj_fifo #(
    .FLIT_W (FLIT_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inj_valid),
    .push_data (inj_data),
    .pop       (inject),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (occupancy)
  );

  assign inj_ready = rst_n & ~full;
  assign any_free  = |free_c;
  assign inject    = ~empty & any_free;
  assign starve    = (starve_cnt == SW'(STARVE_LIMIT));

  // Injected copy has the ejected flag cleared; golden and sequence bits untouched.
  always_comb begin
    head_clr            = head;
    head_clr[EJECT_BIT] = 1'b0;
  end

  // Round-robin pick: first free slot scanning upward from rr_ptr.
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      scan_idx = (32'(rr_ptr) + i) % NUM_PORTS;
      if (!found && free_c[PW'(scan_idx)]) begin
        found = 1'b1;
        sel   = PW'(scan_idx);
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
    assign free_c[p] = ~in_valid[p] | in_flits[p*FLIT_W + EJECT_BIT];
    assign nxt_flits[p*FLIT_W +: FLIT_W] =
      (inject && sel == PW'(p)) ? head_clr :
      (free_c[p]                ? {FLIT_W{1'b0}} : in_flits[p*FLIT_W +: FLIT_W]);
    assign nxt_valid[p] = (inject && sel == PW'(p)) | ~free_c[p];
  end

  // Output registers, grant/port tracking, round-robin pointer and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_flits  <= '0;
      out_valid  <= '0;
      inj_grant  <= 1'b0;
      inj_port   <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      out_flits <= nxt_flits;
      out_valid <= nxt_valid;
      inj_grant <= inject;
      if (inject) begin
        inj_port <= sel;
        rr_ptr   <= (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + PW'(1);
      end
      if (empty || inject) begin
        starve_cnt <= '0;
      end else if (!any_free && starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule
